// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with fill count, almost flags and registered overflow/underflow pulses; rejects writes when full and reads when empty.
// Standard mode: read data one cycle after an accepted read. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic                    read_en,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  // The wrap bit makes the pointer difference an exact fill level, 0..DEPTH.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_comb begin
    wr_acc   = write_en && !full;
    rd_acc   = read_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = write_en && full;
    unf_d    = read_en && empty;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
    if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever observed.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= write_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign read_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign read_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_vld_q, rd_vld_d;

  always_comb begin
    rd_data_d = rd_data_q;
    rd_vld_d  = rd_acc;
    if (rd_acc) rd_data_d = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign read_data  = rd_data_q;
  assign read_valid = rd_vld_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue-based reference model compared every cycle, plus directed literal checks.
module tb_sync_fifo_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          write_en = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          read_en = 1'b0;
  logic [DW-1:0] read_data;
  logic          read_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata = '0;
  logic          m_rvalid = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  int            n_wr = 0;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clock(clock), .reset(reset), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(read_data), .read_valid(read_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge reset) begin
    int sz;
    if (reset) begin
      q.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else begin
      sz       = q.size();
      m_ovf    = write_en && (sz == DEPTH);
      m_unf    = read_en && (sz == 0);
      m_rvalid = 1'b0;
      if (read_en && sz > 0) begin
        m_rdata  = q.pop_front();
        m_rvalid = 1'b1;
      end
      if (write_en && sz < DEPTH) begin
        q.push_back(write_data);
        n_wr++;
      end
    end
  end

  always @(negedge clock) begin
    int sz;
    if (!reset && chk_on) begin
      sz = q.size();
      chk("count", 32'(count), 32'(sz));
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("almost_full", 32'(almost_full), 32'(sz >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
      chk("read_valid", 32'(read_valid), 32'(sz > 0));
      chk("read_data", 32'(read_data), (sz > 0) ? 32'(q[0]) : 32'd0);
`else
      chk("read_valid", 32'(read_valid), 32'(m_rvalid));
      chk("read_data", 32'(read_data), 32'(m_rdata));
`endif
    end
  end

  task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic re);
    write_en   = we;
    write_data = wd;
    read_en    = re;
    @(posedge clock);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 3 * DEPTH && q.size() > 0; g++) cyc(1'b0, '0, 1'b1);
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_rdata", 32'(read_data), 32'd0);
    chk("rst_rvalid", 32'(read_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    @(negedge clock);
    #1 reset = 1'b0;
    chk_on = 1'b1;

    // Fill
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      if (i == 2) chk("fill_ae2", 32'(almost_empty), 32'd1);
      if (i == 3) chk("fill_ae3", 32'(almost_empty), 32'd0);
      if (i == 5) chk("fill_af5", 32'(almost_full), 32'd0);
      if (i == 6) chk("fill_af6", 32'(almost_full), 32'd1);
    end
    chk("fill_full", 32'(full), 32'd1);

    // Overflow and drain
    cyc(1'b1, 8'hFF, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    cyc(1'b0, '0, 1'b0);
    chk("ovf_clear", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("drain_head", 32'(read_data), 32'(8'h11 + k));
      cyc(1'b0, '0, 1'b1);
`else
      cyc(1'b0, '0, 1'b1);
      chk("drain_data", 32'(read_data), 32'(8'h11 + k));
      chk("drain_valid", 32'(read_valid), 32'd1);
`endif
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Underflow
    cyc(1'b0, '0, 1'b1);
    chk("unf_pulse", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    chk("unf_rvalid", 32'(read_valid), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("unf_rdata", 32'(read_data), 32'd0);
`else
    chk("unf_rdata", 32'(read_data), 32'h18);
`endif
    cyc(1'b0, '0, 1'b0);
    chk("unf_clear", 32'(underflow), 32'd0);

    // Simultaneous read and write at count 4
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h21 + i), 1'b0);
    cyc(1'b1, 8'h25, 1'b1);
    chk("rw4_count", 32'(count), 32'd4);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rw4_data", 32'(read_data), 32'h21);
`endif
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h26 + i), 1'b0);
    chk("rw_full", 32'(full), 32'd1);
    cyc(1'b1, 8'h77, 1'b1);
    chk("rwf_ovf", 32'(overflow), 32'd1);
    chk("rwf_count", 32'(count), 32'd7);
    drain();
    cyc(1'b1, 8'h88, 1'b1);
    chk("rwe_unf", 32'(underflow), 32'd1);
    chk("rwe_count", 32'(count), 32'd1);
    drain();

    // Random traffic, enough writes to wrap the pointers several times
    n0 = n_wr;
    for (int c = 0; c < 160; c++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    chk("wrap_writes", 32'((n_wr - n0) >= 3 * DEPTH), 32'd1);

    // Reset mid-operation at count 5
    drain();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_rdata", 32'(read_data), 32'd0);
    chk("mid_rst_rvalid", 32'(read_valid), 32'd0);
    @(negedge clock);
    #1 reset = 1'b0;
    cyc(1'b1, 8'hA5, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("post_rst_rvalid", 32'(read_valid), 32'd1);
    chk("post_rst_rdata", 32'(read_data), 32'hA5);
`else
    chk("post_rst_novalid", 32'(read_valid), 32'd0);
    cyc(1'b0, '0, 1'b1);
    chk("post_rst_rvalid", 32'(read_valid), 32'd1);
    chk("post_rst_rdata", 32'(read_data), 32'hA5);
`endif
    cyc(1'b0, '0, 1'b0);
    @(posedge clock);
    #1;
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
